multicycle_ctrl_fsm: RTL and testbench

Parametrised multicycle MIPS control unit; successor to the first-generation controller.
- Drives the datapath muxes and write enables for the ALU R-type, addi, lw, sw, beq and j instructions.
- Supports a configurable number of memory wait states and an illegal-instruction path.
- Sits between the instruction register (opcode/funct) and the datapath. One instruction in flight; Moore outputs, except the Zero-qualified branch write.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_wait_cnt.sv | 36 +++
 rtl/multicycle_ctrl_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// FSM states and datapath mux select values.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_MWAIT_F, S_IR_LOAD, S_DECODE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
    S_MEM_RD, S_MEM_WR, S_MEM_WB, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_e;

  localparam logic [2:0] IORD_PC     = 3'b100;
  localparam logic [2:0] IORD_ALUOUT = 3'b001;

  localparam logic [2:0] PCSRC_ALU    = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b10;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH = 3'b011;

  localparam logic [3:0] M2R_ALUOUT = 4'b0000;
  localparam logic [3:0] M2R_MDR    = 4'b0001;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b11;

  // Returns {supported, alu_op}; unsupported funct codes report ALU_AND.
  function automatic logic [3:0] func_decode(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return {1'b1, ALU_ADD};
      FN_SUB:  return {1'b1, ALU_SUB};
      FN_AND:  return {1'b1, ALU_AND};
      FN_OR:   return {1'b1, ALU_OR};
      FN_SLT:  return {1'b1, ALU_SLT};
      default: return {1'b0, ALU_AND};
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait-state counter: loads a preset, counts down to zero and holds there.
module ctrl_wait_cnt #(
  parameter int WAIT_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              last,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == WAIT_W'(1));
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control unit (R-type, addi, lw, sw, beq, j) with memory wait states.
// Define CTRL_ILLEGAL_TRAP_EN to make the illegal-instruction state a sticky trap.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 1,
  parameter int WAIT_W          = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       Reset,
  output logic       PCWrite,
  output logic [2:0] IorD,
  output logic       MemWrite,
  output logic       MDRWrite,
  output logic       IRWrite,
  output logic [3:0] MemToReg,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [2:0] PCSrc,
  output logic [2:0] ALUop,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic       ALUout,
  output logic       AWrite,
  output logic       BWrite,
  output logic       illegal_op
);

  localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(MEM_WAIT_CYCLES);
  localparam bit                HAS_WAIT = (MEM_WAIT_CYCLES > 0);

  state_e     state_q, state_d;
  logic       wcnt_load, wcnt_dec, wcnt_last, wcnt_zero;
  logic [3:0] fdec;

  assign fdec = func_decode(func);

  ctrl_wait_cnt #(.WAIT_W(WAIT_W)) u_wait_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (wcnt_load),
    .dec      (wcnt_dec),
    .load_val (WAIT_LD),
    .last     (wcnt_last),
    .zero     (wcnt_zero)
  );

  // Data-memory states stay put until the counter drains, so they span M+1 cycles.
  always_comb begin
    state_d   = state_q;
    wcnt_load = 1'b0;
    wcnt_dec  = 1'b0;
    case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH: begin
        wcnt_load = 1'b1;
        state_d   = HAS_WAIT ? S_MWAIT_F : S_IR_LOAD;
      end
      S_MWAIT_F: begin
        wcnt_dec = 1'b1;
        if (wcnt_last) state_d = S_IR_LOAD;
      end
      S_IR_LOAD: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:  state_d = fdec[3] ? S_WB_R : S_ILLEGAL;
      S_EXEC_I:  state_d = S_WB_I;
      S_ADDR: begin
        wcnt_load = 1'b1;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        wcnt_dec = 1'b1;
        if (wcnt_zero) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        wcnt_dec = 1'b1;
        if (wcnt_zero) state_d = S_FETCH;
      end
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`else
      S_ILLEGAL: state_d = S_FETCH;
`endif
      default:   state_d = S_RST;
    endcase
    if (reset) state_d = S_RST;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_d  = illegal_q | (state_q == S_ILLEGAL);
  assign illegal_op = illegal_d;
`else
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clock) begin
    state_q <= state_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_q <= reset ? 1'b0 : illegal_d;
`endif
  end

  // Moore decode; the branch PC write is the only zero-qualified output.
  always_comb begin
    Reset    = 1'b0;
    PCWrite  = 1'b0;
    IorD     = 3'b000;
    MemWrite = 1'b0;
    MDRWrite = 1'b0;
    IRWrite  = 1'b0;
    MemToReg = M2R_ALUOUT;
    RegWrite = 1'b0;
    RegDst   = RDST_RT;
    PCSrc    = PCSRC_ALU;
    ALUop    = ALU_AND;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_B;
    ALUout   = 1'b0;
    AWrite   = 1'b0;
    BWrite   = 1'b0;
    case (state_q)
      S_RST: Reset = 1'b1;
      S_FETCH: begin
        IorD    = IORD_PC;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        ALUop   = ALU_ADD;
        PCSrc   = PCSRC_ALU;
        PCWrite = 1'b1;
      end
      S_MWAIT_F: IorD = IORD_PC;
      S_IR_LOAD: begin
        IRWrite = 1'b1;
        IorD    = IORD_PC;
      end
      S_DECODE: begin
        AWrite  = 1'b1;
        BWrite  = 1'b1;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_IMM_SH;
        ALUop   = ALU_ADD;
        ALUout  = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_B;
        ALUop   = fdec[2:0];
        ALUout  = fdec[3];
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = RDST_RD;
        MemToReg = M2R_ALUOUT;
      end
      S_EXEC_I, S_ADDR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALU_ADD;
        ALUout  = 1'b1;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
        RegDst   = RDST_RT;
        MemToReg = M2R_ALUOUT;
      end
      S_MEM_RD: begin
        IorD     = IORD_ALUOUT;
        MDRWrite = wcnt_zero;
      end
      S_MEM_WR: begin
        IorD     = IORD_ALUOUT;
        MemWrite = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        RegDst   = RDST_RT;
        MemToReg = M2R_MDR;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_B;
        ALUop   = ALU_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCWrite = zero;
      end
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm with three wait-state settings (M = 1, 0, 3).
// Honours CTRL_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
module tb_multicycle_ctrl_fsm;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]       rst_v;
  logic [2:0][5:0]  opc_v;
  logic [2:0][5:0]  fn_v;
  logic [2:0]       zero_v;
  logic [2:0][29:0] ctl;

  // Packed order: Reset PCWrite IorD MemWrite MDRWrite IRWrite MemToReg RegWrite
  //               RegDst PCSrc ALUop ALUSrcA ALUSrcB ALUout AWrite BWrite illegal_op
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       o_rst, o_pcw, o_memw, o_mdrw, o_irw, o_regw, o_aluo, o_aw, o_bw, o_ill;
    logic [2:0] o_iord, o_pcsrc, o_aluop, o_srcb;
    logic [3:0] o_m2r;
    logic [1:0] o_rdst, o_srca;

    multicycle_ctrl_fsm #(
      .MEM_WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .WAIT_W         (4)
    ) u_dut (
      .clock      (clock),
      .reset      (rst_v[g]),
      .opcode     (opc_v[g]),
      .func       (fn_v[g]),
      .zero       (zero_v[g]),
      .Reset      (o_rst),
      .PCWrite    (o_pcw),
      .IorD       (o_iord),
      .MemWrite   (o_memw),
      .MDRWrite   (o_mdrw),
      .IRWrite    (o_irw),
      .MemToReg   (o_m2r),
      .RegWrite   (o_regw),
      .RegDst     (o_rdst),
      .PCSrc      (o_pcsrc),
      .ALUop      (o_aluop),
      .ALUSrcA    (o_srca),
      .ALUSrcB    (o_srcb),
      .ALUout     (o_aluo),
      .AWrite     (o_aw),
      .BWrite     (o_bw),
      .illegal_op (o_ill)
    );

    assign ctl[g] = {o_rst, o_pcw, o_iord, o_memw, o_mdrw, o_irw, o_m2r, o_regw,
                     o_rdst, o_pcsrc, o_aluop, o_srca, o_srcb, o_aluo, o_aw, o_bw, o_ill};
  end

  localparam logic [29:0] B_RST    = 30'd1 << 29;
  localparam logic [29:0] B_PCW    = 30'd1 << 28;
  localparam logic [29:0] B_IOPC   = 30'd4 << 25;
  localparam logic [29:0] B_IOAO   = 30'd1 << 25;
  localparam logic [29:0] B_MEMW   = 30'd1 << 24;
  localparam logic [29:0] B_MDRW   = 30'd1 << 23;
  localparam logic [29:0] B_IRW    = 30'd1 << 22;
  localparam logic [29:0] B_M2RMDR = 30'd1 << 18;
  localparam logic [29:0] B_REGW   = 30'd1 << 17;
  localparam logic [29:0] B_RDSTRD = 30'd3 << 15;
  localparam logic [29:0] B_PCSAO  = 30'd1 << 12;
  localparam logic [29:0] B_PCSJ   = 30'd2 << 12;
  localparam logic [29:0] B_OPADD  = 30'd1 << 9;
  localparam logic [29:0] B_OPSUB  = 30'd2 << 9;
  localparam logic [29:0] B_SRCA_A = 30'd2 << 7;
  localparam logic [29:0] B_SB4    = 30'd1 << 4;
  localparam logic [29:0] B_SBIMM  = 30'd2 << 4;
  localparam logic [29:0] B_SBBR   = 30'd3 << 4;
  localparam logic [29:0] B_ALUO   = 30'd1 << 3;
  localparam logic [29:0] B_AW     = 30'd1 << 2;
  localparam logic [29:0] B_BW     = 30'd1 << 1;
  localparam logic [29:0] B_ILL    = 30'd1;

  localparam logic [29:0] E_RST    = B_RST;
  localparam logic [29:0] E_FETCH  = B_PCW | B_IOPC | B_SB4 | B_OPADD;
  localparam logic [29:0] E_MWF    = B_IOPC;
  localparam logic [29:0] E_IRL    = B_IRW | B_IOPC;
  localparam logic [29:0] E_DEC    = B_AW | B_BW | B_SBBR | B_OPADD | B_ALUO;
  localparam logic [29:0] E_EXRBAD = B_SRCA_A;
  localparam logic [29:0] E_WBR    = B_REGW | B_RDSTRD;
  localparam logic [29:0] E_EXI    = B_SRCA_A | B_SBIMM | B_OPADD | B_ALUO;
  localparam logic [29:0] E_WBI    = B_REGW;
  localparam logic [29:0] E_MRD    = B_IOAO;
  localparam logic [29:0] E_MRDL   = B_IOAO | B_MDRW;
  localparam logic [29:0] E_MWR    = B_IOAO | B_MEMW;
  localparam logic [29:0] E_MWB    = B_REGW | B_M2RMDR;
  localparam logic [29:0] E_BR0    = B_SRCA_A | B_OPSUB | B_PCSAO;
  localparam logic [29:0] E_BR1    = E_BR0 | B_PCW;
  localparam logic [29:0] E_JMP    = B_PCSJ | B_PCW;

  int n_cmp = 0;
  int n_bad = 0;
  logic [29:0] seq[$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input logic [29:0] v, input int n);
    for (int i = 0; i < n; i++) seq.push_back(v);
  endtask

  task automatic front(input int m);
    seq.push_back(E_FETCH);
    push_n(E_MWF, m);
    seq.push_back(E_IRL);
    seq.push_back(E_DEC);
  endtask

  task automatic run_seq(input int g, input string tag);
    for (int i = 0; i < seq.size(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), ctl[g], seq[i]);
      step();
    end
    seq.delete();
  endtask

  task automatic set_instr(input int g, input logic [5:0] op, input logic [5:0] fn, input logic z);
    opc_v[g]  = op;
    fn_v[g]   = fn;
    zero_v[g] = z;
  endtask

  task automatic reset_pulse(input int g, input string tag);
    rst_v[g] = 1'b1;
    step();
    chk({tag, "_rst"}, ctl[g], E_RST);
    rst_v[g] = 1'b0;
    step();
  endtask

  // Illegal tail: trap holds illegal_op with no writes; otherwise a one-cycle NOP.
  task automatic illegal_tail(input int g, input string tag);
`ifdef CTRL_ILLEGAL_TRAP_EN
    push_n(B_ILL, 3);
    run_seq(g, tag);
    reset_pulse(g, tag);
`else
    seq.push_back(30'd0);
    run_seq(g, tag);
`endif
  endtask

  logic [5:0]  r_fn [5];
  logic [29:0] r_op [5];

  initial begin
    rst_v  = 3'b111;
    opc_v  = '0;
    fn_v   = '0;
    zero_v = '0;
    r_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    r_op = '{30'd1 << 9, 30'd2 << 9, 30'd0, 30'd3 << 9, 30'd7 << 9};

    step();
    step();
    for (int g = 0; g < 3; g++) chk($sformatf("reset_state_%0d", g), ctl[g], E_RST);

    // M = 1
    rst_v[0] = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      set_instr(0, 6'd0, r_fn[k], 1'b0);
      front(1);
      seq.push_back(B_SRCA_A | r_op[k] | B_ALUO);
      seq.push_back(E_WBR);
      run_seq(0, $sformatf("rtype_f%02h", r_fn[k]));
    end
    set_instr(0, 6'd8, 6'h00, 1'b0);
    front(1); seq.push_back(E_EXI); seq.push_back(E_WBI);
    run_seq(0, "addi");
    set_instr(0, 6'd4, 6'h00, 1'b1);
    front(1); seq.push_back(E_BR1);
    run_seq(0, "beq_taken");
    set_instr(0, 6'd4, 6'h00, 1'b0);
    front(1); seq.push_back(E_BR0);
    run_seq(0, "beq_not_taken");
    set_instr(0, 6'd2, 6'h00, 1'b0);
    front(1); seq.push_back(E_JMP);
    run_seq(0, "jump");
    set_instr(0, 6'h3F, 6'h00, 1'b0);
    front(1);
    illegal_tail(0, "illegal_opcode");
    set_instr(0, 6'd0, 6'h01, 1'b0);
    front(1); seq.push_back(E_EXRBAD);
    illegal_tail(0, "illegal_func");
    chk("after_illegal_m1", ctl[0], E_FETCH);

    // M = 0
    rst_v[1] = 1'b0;
    step();
    set_instr(1, 6'd35, 6'h00, 1'b0);
    front(0); seq.push_back(E_EXI); seq.push_back(E_MRDL); seq.push_back(E_MWB);
    run_seq(1, "lw_m0");
    set_instr(1, 6'd43, 6'h00, 1'b0);
    front(0); seq.push_back(E_EXI); seq.push_back(E_MWR);
    run_seq(1, "sw_m0");
    set_instr(1, 6'd0, 6'h20, 1'b0);
    front(0); seq.push_back(B_SRCA_A | B_OPADD | B_ALUO); seq.push_back(E_WBR);
    run_seq(1, "add_m0");
    chk("after_add_m0", ctl[1], E_FETCH);

    // M = 3
    rst_v[2] = 1'b0;
    step();
    set_instr(2, 6'd35, 6'h00, 1'b0);
    front(3); seq.push_back(E_EXI); push_n(E_MRD, 3); seq.push_back(E_MRDL); seq.push_back(E_MWB);
    run_seq(2, "lw_m3");
    set_instr(2, 6'd43, 6'h00, 1'b0);
    front(3); seq.push_back(E_EXI); push_n(E_MWR, 4);
    run_seq(2, "sw_m3");
    front(3); seq.push_back(E_EXI); push_n(E_MWR, 2);
    run_seq(2, "sw_abort");
    chk("sw_abort_mid_wait", ctl[2], E_MWR);
    rst_v[2] = 1'b1;
    step();
    chk("sw_abort_rst", ctl[2], E_RST);
    rst_v[2] = 1'b0;
    step();
    chk("sw_abort_fetch", ctl[2], E_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
